// File: rtl/tx_frame_wrapper_pkg.sv
// Shared definitions for the TX frame wrapper: FSM states, header layout, default sync word.
// The default MAGIC value is also what the host-side parser searches for.
// Header word layout: [31:16] magic, [15:0] frame sequence number.
package tx_frame_wrapper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAD  = 3'd1,
    ST_DATA  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_CSUM  = 3'd4,
    ST_FINAL = 3'd5
  } state_t;

  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_SEQ_LSB   = 0;

  localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

  // Assemble a header word from its two fields
  function automatic logic [31:0] make_header(input logic [15:0] magic, input logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 16] = magic;
    w[HDR_SEQ_LSB +: 16]   = seq;
    return w;
  endfunction

endpackage

// File: rtl/tx_keep_count.sv
// Purpose: per-beat enabled-byte count and enabled-byte sum from tdata/tkeep.
// Latency: combinational, 0 clk.
// Backpressure: none; pure function of the current beat.
module tx_keep_count (
  input  logic [31:0] beat_dat,
  input  logic [3:0]  beat_keep,
  output logic [2:0]  byte_cnt,
  output logic [9:0]  byte_sum
);

  // Walk the four byte lanes, counting and summing only the enabled ones
  always_comb begin
    byte_cnt = '0;
    byte_sum = '0;
    for (int b = 0; b < 4; b++) begin
      if (beat_keep[b]) begin
        byte_cnt = byte_cnt + 3'd1;
        byte_sum = byte_sum + {2'b00, beat_dat[8*b +: 8]};
      end
    end
  end

endmodule

// File: rtl/tx_frame_wrapper.sv
// Purpose: wraps each 32-bit AXI-stream packet as {header, payload..., byte-count trailer[, checksum]}.
// Latency: payload in->out 1 clk; header costs one extra word before the first payload beat.
// Backpressure: single output slot, i_tready only in DATA while the slot is free; TX_FRAME_CSUM_EN adds a checksum word.
module tx_frame_wrapper
  import tx_frame_wrapper_pkg::*;
#(
  parameter logic [15:0] MAGIC    = MAGIC_DEFAULT,
  parameter logic [15:0] SEQ_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tlast,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep,
  output logic        o_tlast
);

  state_t      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
`ifdef TX_FRAME_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif
  logic        o_tvalid_q, o_tvalid_d;
  logic [31:0] o_tdata_q, o_tdata_d;
  logic [3:0]  o_tkeep_q, o_tkeep_d;
  logic        o_tlast_q, o_tlast_d;

  logic        slot_free;
  logic        beat_acc;
  logic [2:0]  beat_cnt;
  logic [9:0]  beat_sum;

  tx_keep_count u_keep_count (
    .beat_dat  (i_tdata),
    .beat_keep (i_tkeep),
    .byte_cnt  (beat_cnt),
    .byte_sum  (beat_sum)
  );

`ifndef TX_FRAME_CSUM_EN
  logic unused_sum;
  assign unused_sum = ^beat_sum;
`endif

  assign slot_free = ~o_tvalid_q | o_tready;
  assign i_tready  = (state_q == ST_DATA) & slot_free;
  assign beat_acc  = i_tvalid & i_tready;

  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tkeep  = o_tkeep_q;
  assign o_tlast  = o_tlast_q;

  // Frame sequencing and output-slot loading; the slot empties by default when the sink takes it
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    byte_cnt_d = byte_cnt_q;
`ifdef TX_FRAME_CSUM_EN
    csum_d     = csum_q;
`endif
    o_tvalid_d = o_tvalid_q & ~o_tready;
    o_tdata_d  = o_tdata_q;
    o_tkeep_d  = o_tkeep_q;
    o_tlast_d  = o_tlast_q;

    case (state_q)
      ST_IDLE: begin
        // A pending beat triggers the header; the beat itself waits for DATA
        if (i_tvalid) begin
          o_tvalid_d = 1'b1;
          o_tdata_d  = make_header(MAGIC, seq_q);
          o_tkeep_d  = 4'hF;
          o_tlast_d  = 1'b0;
          state_d    = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (o_tready) begin
          byte_cnt_d = '0;
`ifdef TX_FRAME_CSUM_EN
          csum_d     = '0;
`endif
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_acc) begin
          byte_cnt_d = byte_cnt_q + {29'd0, beat_cnt};
`ifdef TX_FRAME_CSUM_EN
          csum_d     = csum_q + {22'd0, beat_sum};
`endif
          // Empty beats only contribute to the count, never to the output stream
          if (i_tkeep != 4'h0) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = i_tdata;
            o_tkeep_d  = i_tkeep;
            o_tlast_d  = 1'b0;
          end
          if (i_tlast) begin
            state_d = ST_TRAIL;
          end
        end
      end
      ST_TRAIL: begin
        if (slot_free) begin
          o_tvalid_d = 1'b1;
          o_tdata_d  = byte_cnt_q;
          o_tkeep_d  = 4'hF;
`ifdef TX_FRAME_CSUM_EN
          o_tlast_d  = 1'b0;
          state_d    = ST_CSUM;
`else
          o_tlast_d  = 1'b1;
          state_d    = ST_FINAL;
`endif
        end
      end
`ifdef TX_FRAME_CSUM_EN
      ST_CSUM: begin
        if (slot_free) begin
          o_tvalid_d = 1'b1;
          o_tdata_d  = csum_q;
          o_tkeep_d  = 4'hF;
          o_tlast_d  = 1'b1;
          state_d    = ST_FINAL;
        end
      end
`endif
      ST_FINAL: begin
        // Sequence advances only once the closing word has actually left
        if (o_tready) begin
          seq_d   = seq_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output-slot registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      seq_q      <= SEQ_INIT;
      byte_cnt_q <= '0;
`ifdef TX_FRAME_CSUM_EN
      csum_q     <= '0;
`endif
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tkeep_q  <= '0;
      o_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef TX_FRAME_CSUM_EN
      csum_q     <= csum_d;
`endif
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tkeep_q  <= o_tkeep_d;
      o_tlast_q  <= o_tlast_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_wrapper.sv
// Bench for tx_frame_wrapper: scoreboard of expected output words, checked by a monitor.
// A second instance with SEQ_INIT=FFFF shares the stimulus to observe sequence wrap.
// Define TX_FRAME_CSUM_EN for both bench and RTL to cover the checksum build.
module tb_tx_frame_wrapper;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tready;
  logic        i_tready,  o_tvalid,  o_tlast;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep;
  logic        i_tready2, o2_tvalid, o2_tlast;
  logic [31:0] o2_tdata;
  logic [3:0]  o2_tkeep;

  always #5 clk = ~clk;

  tx_frame_wrapper dut (
    .clk(clk), .rstn(rstn),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tlast(o_tlast)
  );

  tx_frame_wrapper #(.SEQ_INIT(16'hFFFF)) dut2 (
    .clk(clk), .rstn(rstn),
    .i_tready(i_tready2), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o2_tvalid), .o_tdata(o2_tdata), .o_tkeep(o2_tkeep), .o_tlast(o2_tlast)
  );

  int          total = 0;
  int          bad   = 0;
  logic [36:0] exp1_q[$];
  logic [36:0] exp2_q[$];
  logic [31:0] bd[$];
  logic [3:0]  bk[$];
  logic [15:0] seq1, seq2;
  bit          stall_mode = 1'b0;

  // Sink ready: always on, or a coin flip per cycle in stall mode
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_both(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp1_q.push_back({d, k, l});
    exp2_q.push_back({d, k, l});
  endtask

  task automatic push_hdr();
    exp1_q.push_back({16'hA55A, seq1, 4'hF, 1'b0});
    exp2_q.push_back({16'hA55A, seq2, 4'hF, 1'b0});
    seq1 = seq1 + 16'd1;
    seq2 = seq2 + 16'd1;
  endtask

  // Expected frame for the packet held in bd/bk
  task automatic push_frame();
    logic [31:0] cnt, cs;
    cnt = 0;
    cs  = 0;
    push_hdr();
    foreach (bd[i]) begin
      cnt = cnt + 32'($countones(bk[i]));
      for (int b = 0; b < 4; b++)
        if (bk[i][b]) cs = cs + {24'd0, bd[i][8*b +: 8]};
      if (bk[i] != 4'h0) push_both(bd[i], bk[i], 1'b0);
    end
`ifdef TX_FRAME_CSUM_EN
    push_both(cnt, 4'hF, 1'b0);
    push_both(cs, 4'hF, 1'b1);
`else
    push_both(cnt, 4'hF, 1'b1);
`endif
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    int   n;
    i_tvalid = 1'b1; i_tdata = d; i_tkeep = k; i_tlast = l;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout: got no i_tready in %0d cycles, expected accept", n);
    end
    i_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int gap_max);
    foreach (bd[i]) begin
      drive_beat(bd[i], bk[i], (i == bd.size() - 1));
      if (gap_max > 0 && i != bd.size() - 1)
        repeat ($urandom_range(1, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp1_q.size() != 0 || exp2_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 37'(exp1_q.size() + exp2_q.size()), 37'd0);
  endtask

  initial begin
    logic [3:0] keeps [5];
    logic [36:0] prev1;
    bit stall1;
    keeps[0] = 4'hF; keeps[1] = 4'h7; keeps[2] = 4'h3; keeps[3] = 4'h1; keeps[4] = 4'h0;
    stall1 = 1'b0;
    prev1  = '0;
    rstn = 1'b0; i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0;
    seq1 = 16'h0000; seq2 = 16'hFFFF;
    fork
      // Monitor: compare every accepted output word and hold-stability while stalled
      forever begin
        @(negedge clk);
        if (!rstn) begin
          stall1 = 1'b0;
        end else begin
          if (stall1) check("stall_stable", {o_tdata, o_tkeep, o_tlast}, prev1);
          if (stall1) check("stall_valid", {36'd0, o_tvalid}, 37'd1);
          if (o_tvalid && o_tready) begin
            if (exp1_q.size() == 0) check("unexpected_word", {o_tdata, o_tkeep, o_tlast}, 37'h1FFFFFFFFF);
            else check("out_word", {o_tdata, o_tkeep, o_tlast}, exp1_q.pop_front());
          end
          if (o2_tvalid && o_tready) begin
            if (exp2_q.size() == 0) check("unexpected_word2", {o2_tdata, o2_tkeep, o2_tlast}, 37'h1FFFFFFFFF);
            else check("out_word2", {o2_tdata, o2_tkeep, o2_tlast}, exp2_q.pop_front());
          end
          stall1 = o_tvalid && !o_tready;
          prev1  = {o_tdata, o_tkeep, o_tlast};
        end
      end
      begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {o_tdata, o_tkeep, o_tlast}, 37'd0);
        check("rst_valid_ready", {35'd0, o_tvalid, i_tready}, 37'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two-beat packet with hand-computed frame: count 6, checksum 0x15
        exp1_q.push_back({32'hA55A0000, 4'hF, 1'b0});
        exp2_q.push_back({32'hA55AFFFF, 4'hF, 1'b0});
        seq1 = 16'h0001; seq2 = 16'h0000;
        push_both(32'h04030201, 4'hF, 1'b0);
        push_both(32'h00000605, 4'h3, 1'b0);
`ifdef TX_FRAME_CSUM_EN
        push_both(32'h00000006, 4'hF, 1'b0);
        push_both(32'h00000015, 4'hF, 1'b1);
`else
        push_both(32'h00000006, 4'hF, 1'b1);
`endif
        drive_beat(32'h04030201, 4'hF, 1'b0);
        drive_beat(32'h00000605, 4'h3, 1'b1);

        // Three back-to-back packets (second instance wraps FFFF -> 0000 -> 0001)
        for (int p = 0; p < 3; p++) begin
          bd.delete(); bk.delete();
          for (int i = 0; i <= p; i++) begin
            bd.push_back(32'h11223344 + 32'(p * 16 + i));
            bk.push_back(keeps[(p + i) % 4]);
          end
          push_frame();
          send_pkt(0);
        end

        // Input gaps of 1-5 clk mid-packet
        bd.delete(); bk.delete();
        bd.push_back(32'hDEADBEEF); bk.push_back(4'hF);
        bd.push_back(32'h00000000); bk.push_back(4'h0);
        bd.push_back(32'h00CAFE12); bk.push_back(4'h7);
        bd.push_back(32'h000000AB); bk.push_back(4'h1);
        push_frame();
        send_pkt(5);
        wait_drain();

        // Reset after three payload beats; partial frame dropped, seq restarts
        bd.delete(); bk.delete();
        for (int i = 0; i < 6; i++) begin bd.push_back(32'h01010101 * 32'(i + 1)); bk.push_back(4'hF); end
        push_frame();
        for (int i = 0; i < 3; i++) drive_beat(bd[i], bk[i], 1'b0);
        check("pre_rst_valid", {36'd0, o_tvalid}, 37'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", {35'd0, o_tvalid, o2_tvalid}, 37'd0);
        check("rst_mid_ready", {36'd0, i_tready}, 37'd0);
        exp1_q.delete(); exp2_q.delete();
        seq1 = 16'h0000; seq2 = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        bd.delete(); bk.delete();
        bd.push_back(32'h0000BEEF); bk.push_back(4'h3);
        push_frame();
        send_pkt(0);

        // Zero-byte packet: header then zero trailer, no payload word
        exp1_q.push_back({32'hA55A0001, 4'hF, 1'b0});
        exp2_q.push_back({32'hA55A0000, 4'hF, 1'b0});
        seq1 = 16'h0002; seq2 = 16'h0001;
`ifdef TX_FRAME_CSUM_EN
        push_both(32'h00000000, 4'hF, 1'b0);
        push_both(32'h00000000, 4'hF, 1'b1);
`else
        push_both(32'h00000000, 4'hF, 1'b1);
`endif
        drive_beat(32'h00000000, 4'h0, 1'b1);
        wait_drain();

        // Random sink stalls over many packets
        stall_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
          bd.delete(); bk.delete();
          repeat ($urandom_range(1, 4)) begin
            bd.push_back($urandom());
            bk.push_back(keeps[$urandom_range(0, 4)]);
          end
          push_frame();
          send_pkt(0);
        end
        wait_drain();
        stall_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule
